// File: rtl/mult_pkg.sv
// Shared types and defaults for the HI/LO multiply sequencing controller.
package mult_pkg;

    typedef enum logic [1:0] {
        MULTU = 2'd0,
        MULT  = 2'd1,
        MTHI  = 2'd2,
        MTLO  = 2'd3
    } mult_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        WRITE = 2'd2
    } mult_state_e;

    localparam int WIDTH_DEFAULT       = 32;
    localparam int MUL_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/mult_sign_adjust.sv
// Operand magnitude and 2*WIDTH conditional negate for signed MULT.
// Only compiled into the design when MULT_SIGNED_EN is defined.
module mult_sign_adjust #(
    parameter int WIDTH = 32
) (
    input  logic               sign_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg,
    input  logic               prod_neg,
    input  logic [2*WIDTH-1:0] prod,
    output logic [2*WIDTH-1:0] prod_adj
);

    // Magnitude of the most negative value wraps back to itself, which is the
    // correct unsigned magnitude, so no overflow handling is needed.
    always_comb begin
        mag_a    = (sign_en && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        mag_b    = (sign_en && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        neg      = sign_en && (a[WIDTH-1] ^ b[WIDTH-1]);
        prod_adj = prod_neg ? (~prod + (2*WIDTH)'(1)) : prod;
    end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequences MULT/MULTU/MTHI/MTLO against a fixed-latency pipelined multiplier
// and owns HI/LO. Signed MULT support is built only with MULT_SIGNED_EN.
//
// state | meaning
// IDLE  | ready for an op; MTHI/MTLO complete here in one cycle
// BUSY  | product in flight, cnt counts down the multiplier latency
// WRITE | multiplier output valid; HI/LO captured at the end of this cycle
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             stall,
    output logic             busy,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   op_mag_a, op_mag_b;
    logic [2*WIDTH-1:0] prod_wr;
    mult_op_e           op_e;
    logic               mul_accept;

    assign op_e       = mult_op_e'(op_code);
    assign mul_accept = (state_q == IDLE) && op_valid && ((op_e == MULTU) || (op_e == MULT));

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_d, op_neg;

    mult_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
        .sign_en  (op_e == MULT),
        .a        (op_a),
        .b        (op_b),
        .mag_a    (op_mag_a),
        .mag_b    (op_mag_b),
        .neg      (op_neg),
        .prod_neg (neg_q),
        .prod     ({mul_hi, mul_lo}),
        .prod_adj (prod_wr)
    );

    always_comb begin
        neg_d = neg_q;
        if (mul_accept) neg_d = op_neg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= neg_d;
    end
`else
    assign op_mag_a = op_a;
    assign op_mag_b = op_b;
    assign prod_wr  = {mul_hi, mul_lo};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        mul_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mul_accept) begin
                    mul_a_d = op_mag_a;
                    mul_b_d = op_mag_b;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end else if (op_valid && (op_e == MTHI)) begin
                    hi_d = op_a;
                end else if (op_valid && (op_e == MTLO)) begin
                    lo_d = op_a;
                end
            end
            BUSY: begin
                mul_en = 1'b1;
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WRITE: begin
                mul_en       = 1'b1;
                {hi_d, lo_d} = prod_wr;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    // Reads are unblocked by state alone: an op accepted this cycle has not
    // raised busy yet, so the requester sees the pre-op HI/LO.
    assign op_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign stall    = mf_req && busy;
    assign mf_data  = mf_sel ? hi_q : lo_q;
    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
